rs_key_mds_seq: RTL and testbench

// - Sequential, length-configurable Twofish RS key encoder; next generation of the fixed 128-bit RS matrix block.
// - Each 64-bit key chunk m_i gives S-word S_i = RS(4x8) * m_i over GF(2^8), reduction polynomial 0x14D.
// - Supports 128/192/256-bit keys (k = 2/3/4 chunks) at a throughput of BPC bytes/cycle.
// - Sits in the key-expansion path between the key register and the S-box key-dependent stage.

---
 rtl/rs_pkg.sv | 36 +++
 rtl/gf256_mul.sv | 25 ++
 rtl/rs_key_mds_seq.sv | 136 +++++++++++++
 tb/tb_rs_key_mds_seq.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Shared constants and types for the sequential Twofish RS key encoder.
package rs_pkg;

    localparam logic [8:0] RS_GF_POLY = 9'h14D;

    // Row r, column c of the Twofish RS matrix.
    localparam logic [7:0] RS_MATRIX [4][8] = '{
        '{8'h01, 8'hA4, 8'h55, 8'h87, 8'h5A, 8'h58, 8'hDB, 8'h9E},
        '{8'hA4, 8'h56, 8'h82, 8'hF3, 8'h1E, 8'hC6, 8'h68, 8'hE5},
        '{8'h02, 8'hA1, 8'hFC, 8'hC1, 8'h47, 8'hAE, 8'h3D, 8'h19},
        '{8'hA4, 8'h55, 8'h87, 8'h5A, 8'h58, 8'hDB, 8'h9E, 8'h03}
    };

    typedef enum logic [1:0] {
        KEY_128  = 2'd0,
        KEY_192  = 2'd1,
        KEY_256  = 2'd2,
        KEY_RSVD = 2'd3
    } key_len_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Reserved length code behaves as a 256-bit key.
    function automatic logic [2:0] chunk_count(key_len_t len);
        case (len)
            KEY_128: chunk_count = 3'd2;
            KEY_192: chunk_count = 3'd3;
            default: chunk_count = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/gf256_mul.sv
// Combinational GF(2^8) multiplier: carry-less 8x8 product reduced modulo POLY.
module gf256_mul #(
    parameter logic [8:0] POLY = 9'h14D
) (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] p
);

    logic [14:0] prod;

    always_comb begin
        prod = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) prod = prod ^ (15'(a) << i);
        end
        // Fold the high bits back down, most significant first.
        for (int i = 14; i >= 8; i--) begin
            if (prod[i]) prod = prod ^ (15'(POLY) << (i - 8));
        end
    end

    assign p = prod[7:0];

endmodule

// File: rtl/rs_key_mds_seq.sv
// Sequential Twofish RS key encoder: BPC key bytes per cycle, 128/192/256-bit keys.
module rs_key_mds_seq
    import rs_pkg::*;
#(
    parameter int         BPC     = 8,
    parameter logic [8:0] GF_POLY = RS_GF_POLY
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] key_in,
    input  logic [1:0]   key_len,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] s_out,
    output logic [2:0]   s_count
);

    if (!(BPC == 1 || BPC == 2 || BPC == 4 || BPC == 8)) begin : g_bad_bpc
        $error("rs_key_mds_seq: BPC must be 1, 2, 4 or 8");
    end

    state_t       state, state_next;
    logic [255:0] key_sh;
    logic [2:0]   k_reg;
    logic [5:0]   cnt;
    logic [7:0]   acc      [4];
    logic [7:0]   acc_next [4];
    logic [7:0]   coef     [4][BPC];
    logic [7:0]   prod     [4][BPC];
    logic [127:0] s_reg;
    logic [3:0]   col_end;
    logic         chunk_end;
    logic         last_beat;

    // All BPC bytes of a beat fall in the same chunk because BPC divides 8.
    assign col_end   = 4'({1'b0, cnt[2:0]}) + 4'(BPC);
    assign chunk_end = (col_end == 4'd8);
    assign last_beat = chunk_end && (cnt[4:3] == 2'(k_reg - 3'd1));

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            for (int b = 0; b < BPC; b++) begin
                coef[r][b] = RS_MATRIX[r][3'(cnt[2:0] + 3'(b))];
            end
        end
    end

    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar b = 0; b < BPC; b++) begin : g_byte
            gf256_mul #(.POLY(GF_POLY)) u_mul (
                .a (key_sh[255 - 8*b -: 8]),
                .b (coef[r][b]),
                .p (prod[r][b])
            );
        end
    end

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            acc_next[r] = acc[r];
            for (int b = 0; b < BPC; b++) begin
                acc_next[r] = acc_next[r] ^ prod[r][b];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (last_beat) state_next = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_sh <= '0;
            k_reg  <= '0;
            cnt    <= '0;
            s_reg  <= '0;
            for (int r = 0; r < 4; r++) acc[r] <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        key_sh <= key_in;
                        k_reg  <= chunk_count(key_len_t'(key_len));
                        cnt    <= '0;
                        s_reg  <= '0;
                        for (int r = 0; r < 4; r++) acc[r] <= '0;
                    end
                end
                ST_RUN: begin
                    // Consumed bytes leave through the top so the next ones sit at [255 -: 8*BPC].
                    key_sh <= key_sh << (8 * BPC);
                    cnt    <= cnt + 6'(BPC);
                    if (chunk_end) begin
                        for (int i = 0; i < 4; i++) begin
                            if (cnt[4:3] == 2'(i)) begin
                                s_reg[127 - 32*i -: 32] <= {acc_next[0], acc_next[1],
                                                            acc_next[2], acc_next[3]};
                            end
                        end
                        for (int r = 0; r < 4; r++) acc[r] <= '0;
                    end else begin
                        for (int r = 0; r < 4; r++) acc[r] <= acc_next[r];
                    end
                end
                default: ;
            endcase
        end
    end

    assign s_out   = s_reg;
    assign s_count = k_reg;

endmodule

// File: tb/tb_rs_key_mds_seq.sv
// Scoreboard bench for rs_key_mds_seq at BPC = 1, 2, 4 and 8 (instance d has BPC = 1 << d).
module tb_rs_key_mds_seq;

    localparam logic [7:0] RS_T [4][8] = '{
        '{8'h01, 8'hA4, 8'h55, 8'h87, 8'h5A, 8'h58, 8'hDB, 8'h9E},
        '{8'hA4, 8'h56, 8'h82, 8'hF3, 8'h1E, 8'hC6, 8'h68, 8'hE5},
        '{8'h02, 8'hA1, 8'hFC, 8'hC1, 8'h47, 8'hAE, 8'h3D, 8'h19},
        '{8'hA4, 8'h55, 8'h87, 8'h5A, 8'h58, 8'hDB, 8'h9E, 8'h03}
    };

    typedef struct {
        logic [127:0] s;
        logic [2:0]   k;
        int           lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   in_valid, in_ready, out_valid, out_ready;
    logic [255:0] key_in;
    logic [1:0]   key_len;
    logic [127:0] s_out   [4];
    logic [2:0]   s_count [4];

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        rs_key_mds_seq #(.BPC(1 << g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .key_in    (key_in),
            .key_len   (key_len),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .s_out     (s_out[g]),
            .s_count   (s_count[g])
        );
    end

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] r;
        logic       c;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) r = r ^ a;
            c = a[7];
            a = a << 1;
            if (c) a = a ^ 8'h4D;
            b = b >> 1;
        end
        return r;
    endfunction

    function automatic logic [2:0] model_k(logic [1:0] len);
        return (len == 2'd0) ? 3'd2 : (len == 2'd1) ? 3'd3 : 3'd4;
    endfunction

    function automatic exp_t model(logic [255:0] key, logic [1:0] len, int d);
        exp_t e;
        logic [7:0] kb;
        e.s   = '0;
        e.k   = model_k(len);
        e.lat = 8 * int'(e.k) / (1 << d);
        for (int i = 0; i < int'(e.k); i++)
            for (int j = 0; j < 8; j++) begin
                kb = key[255 - 8*(8*i + j) -: 8];
                for (int r = 0; r < 4; r++)
                    e.s[127 - 32*i - 8*r -: 8] = e.s[127 - 32*i - 8*r -: 8] ^ gmul(RS_T[r][j], kb);
            end
        return e;
    endfunction

    function automatic logic [255:0] rand_key();
        logic [255:0] k;
        for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
        return k;
    endfunction

    // Accept one key on instance d, wait for its result, then complete the output handshake.
    task automatic drive_key(input int d, input logic [255:0] key, input logic [1:0] len,
                             output int lat, output logic [127:0] s, output logic [2:0] k);
        key_in      = key;
        key_len     = len;
        in_valid[d] = 1'b1;
        @(negedge clk);
        in_valid[d] = 1'b0;
        lat = 0;
        while (out_valid[d] !== 1'b1 && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        s = s_out[d];
        k = s_count[d];
        out_ready[d] = 1'b1;
        @(negedge clk);
        out_ready[d] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = '0; out_ready = '0; key_in = '0; key_len = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            n_cmp++;
            if ({in_ready[d], out_valid[d], s_out[d], s_count[d]} !== {2'b10, 128'h0, 3'd0}) begin
                n_err++;
                $display("FAIL reset d=%0d: got rdy=%b vld=%b s=%h cnt=%0d, want rdy=1 vld=0 s=0 cnt=0",
                         d, in_ready[d], out_valid[d], s_out[d], s_count[d]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero_key();
        int lat; logic [127:0] s; logic [2:0] k; exp_t e;
        for (int d = 0; d < 4; d++)
            for (int len = 0; len < 4; len++) begin
                sb.push_back(model('0, 2'(len), d));
                drive_key(d, '0, 2'(len), lat, s, k);
                e = sb.pop_front();
                n_cmp++;
                if (s !== 128'h0 || k !== e.k || lat !== e.lat) begin
                    n_err++;
                    $display("FAIL zero_key d=%0d len=%0d: got s=%h cnt=%0d lat=%0d, want s=0 cnt=%0d lat=%0d",
                             d, len, s, k, lat, e.k, e.lat);
                end
            end
    endtask

    task automatic test_vectors();
        int lat; logic [127:0] s; logic [2:0] k; exp_t e;
        logic [255:0] keys [4];
        logic [1:0]   lens [4];
        logic [127:0] wants[4];
        keys[0] = {8'h01, 248'h0}; lens[0] = 2'd0; wants[0] = {32'h01A402A4, 96'h0};
        keys[1] = {8'h02, 248'h0}; lens[1] = 2'd0; wants[1] = {32'h02050405, 96'h0};
        keys[2] = 256'h1;          lens[2] = 2'd2; wants[2] = {96'h0, 32'h9EE51903};
        keys[3] = 256'h1;          lens[3] = 2'd1; wants[3] = 128'h0;
        for (int d = 0; d < 4; d += 3)
            for (int v = 0; v < 4; v++) begin
                e.s = wants[v]; e.k = model_k(lens[v]); e.lat = 8 * int'(e.k) / (1 << d);
                sb.push_back(e);
                drive_key(d, keys[v], lens[v], lat, s, k);
                e = sb.pop_front();
                n_cmp++;
                if (s !== e.s || k !== e.k || lat !== e.lat) begin
                    n_err++;
                    $display("FAIL vector%0d d=%0d: got s=%h cnt=%0d lat=%0d, want s=%h cnt=%0d lat=%0d",
                             v, d, s, k, lat, e.s, e.k, e.lat);
                end
            end
    endtask

    task automatic test_random();
        int lat; logic [127:0] s; logic [2:0] k; exp_t e;
        logic [255:0] key; logic [1:0] len;
        for (int d = 0; d < 4; d++)
            for (int n = 0; n < 6; n++) begin
                key = rand_key();
                len = 2'($urandom_range(0, 3));
                sb.push_back(model(key, len, d));
                drive_key(d, key, len, lat, s, k);
                e = sb.pop_front();
                n_cmp++;
                if (s !== e.s || k !== e.k || lat !== e.lat) begin
                    n_err++;
                    $display("FAIL random d=%0d n=%0d: got s=%h cnt=%0d lat=%0d, want s=%h cnt=%0d lat=%0d",
                             d, n, s, k, lat, e.s, e.k, e.lat);
                end
            end
    endtask

    task automatic test_back_to_back(input int d);
        int got = 0;
        out_ready[d] = 1'b1;
        fork
            begin : drv
                logic [255:0] key; logic [1:0] len; logic rdy; int wait_cyc;
                for (int n = 0; n < 8; n++) begin
                    key = rand_key();
                    len = 2'($urandom_range(0, 3));
                    sb.push_back(model(key, len, d));
                    key_in = key; key_len = len; in_valid[d] = 1'b1;
                    wait_cyc = 0;
                    do begin
                        rdy = in_ready[d];
                        @(negedge clk);
                        wait_cyc++;
                    end while (!rdy && wait_cyc < 200);
                end
                in_valid[d] = 1'b0;
            end
            begin : mon
                exp_t e; int cyc = 0;
                while (got < 8 && cyc < 2000) begin
                    @(negedge clk);
                    cyc++;
                    if (out_valid[d]) begin
                        n_cmp++;
                        if (sb.size() == 0) begin
                            n_err++;
                            $display("FAIL b2b d=%0d: got unexpected output s=%h, want none pending", d, s_out[d]);
                        end else begin
                            e = sb.pop_front();
                            if (s_out[d] !== e.s || s_count[d] !== e.k) begin
                                n_err++;
                                $display("FAIL b2b d=%0d #%0d: got s=%h cnt=%0d, want s=%h cnt=%0d",
                                         d, got, s_out[d], s_count[d], e.s, e.k);
                            end
                        end
                        got++;
                    end
                end
            end
        join
        out_ready[d] = 1'b0;
        n_cmp++;
        if (got !== 8) begin
            n_err++;
            $display("FAIL b2b_count d=%0d: got %0d results, want 8", d, got);
        end
        sb.delete();
        @(negedge clk);
    endtask

    task automatic test_hold();
        exp_t e; int lat = 0; logic [255:0] key;
        key = rand_key();
        e = model(key, 2'd2, 2);
        sb.push_back(e);
        key_in = key; key_len = 2'd2; in_valid[2] = 1'b1;
        @(negedge clk);
        in_valid[2] = 1'b0;
        while (out_valid[2] !== 1'b1 && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        for (int c = 0; c < 5; c++) begin
            key_in = ~key; key_len = 2'd0; in_valid[2] = 1'b1;
            @(negedge clk);
            n_cmp++;
            if (s_out[2] !== e.s || s_count[2] !== e.k || in_ready[2] !== 1'b0 || out_valid[2] !== 1'b1) begin
                n_err++;
                $display("FAIL hold c=%0d: got s=%h cnt=%0d rdy=%b vld=%b, want s=%h cnt=%0d rdy=0 vld=1",
                         c, s_out[2], s_count[2], in_ready[2], out_valid[2], e.s, e.k);
            end
        end
        // in_valid stays high through the handshake edge; it must not be taken there.
        out_ready[2] = 1'b1;
        @(negedge clk);
        out_ready[2] = 1'b0;
        in_valid[2]  = 1'b0;
        n_cmp++;
        if (out_valid[2] !== 1'b0 || in_ready[2] !== 1'b1 || s_out[2] !== e.s) begin
            n_err++;
            $display("FAIL hold_release: got vld=%b rdy=%b s=%h, want vld=0 rdy=1 s=%h",
                     out_valid[2], in_ready[2], s_out[2], e.s);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int seen = 0;
        key_in = rand_key(); key_len = 2'd2; in_valid[0] = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || s_count[0] !== 3'd0 || s_out[0] !== 128'h0) begin
            n_err++;
            $display("FAIL reset_mid_run: got vld=%b rdy=%b cnt=%0d s=%h, want vld=0 rdy=1 cnt=0 s=0",
                     out_valid[0], in_ready[0], s_count[0], s_out[0]);
        end
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (out_valid[0] || !in_ready[0]) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL reset_drop: got %0d cycles with output/busy after reset, want 0", seen);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_zero_key();
        test_vectors();
        test_random();
        test_back_to_back(3);
        test_back_to_back(1);
        test_hold();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
